// File: rtl/cfg_link_defs_pkg.sv
// Link-level constants shared by the telecommand receiver, the frame parser and the
// trigger configuration register bank.
package cfg_link_defs_pkg;

   localparam logic [7:0] CFG_HDR0     = 8'hEB;
   localparam logic [7:0] CFG_HDR1     = 8'h90;
   localparam logic [7:0] CFG_ADDR_MAX = 8'd19;
   localparam int         CFG_TIMEOUT  = 5000;

   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_ADDR    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SYNC = 3'd1,
      S_ADDR = 3'd2,
      S_DHI  = 3'd3,
      S_DLO  = 3'd4,
      S_CSUM = 3'd5
   } state_t;

endpackage

// File: rtl/config_frame_parser_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 16'h0000;
      end else if (clr) begin
         cnt <= 16'h0000;
      end else if (inc && (cnt != 16'hFFFF)) begin
         cnt <= cnt + 16'h0001;
      end
   end

endmodule

// File: rtl/config_frame_parser.sv
// Turns the telecommand byte stream into checked register-write frames:
// EB 90 ADDR DHI DLO CSUM, with CSUM = ADDR+DHI+DLO mod 256.
module config_frame_parser #(
   parameter logic [7:0] HDR0        = cfg_link_defs_pkg::CFG_HDR0,
   parameter logic [7:0] HDR1        = cfg_link_defs_pkg::CFG_HDR1,
   parameter logic [7:0] ADDR_MAX    = cfg_link_defs_pkg::CFG_ADDR_MAX,
   parameter int         TIMEOUT_CYC = cfg_link_defs_pkg::CFG_TIMEOUT
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [7:0]  byte_in,
   input  logic        byte_vld_in,
   output logic        wr_out,
   output logic [7:0]  wr_addr_out,
   output logic [15:0] data_out,
   output logic        frame_err_out,
   output logic [1:0]  err_code_out,
   output logic [15:0] frame_cnt_out,
   output logic [15:0] err_cnt_out,
   output logic        busy_out
);

   import cfg_link_defs_pkg::*;

   localparam int                TMO_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [7:0]        addr_q, addr_d, hi_q, hi_d, lo_q, lo_d, sum_q, sum_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              wr_evt, err_evt;
   logic [1:0]        err_code_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         addr_q  <= 8'h00;
         hi_q    <= 8'h00;
         lo_q    <= 8'h00;
         sum_q   <= 8'h00;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sum_q   <= sum_d;
         tmo_q   <= tmo_d;
      end
   end

   // A byte strobe always beats a timeout landing in the same cycle.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      sum_d      = sum_q;
      tmo_d      = '0;
      wr_evt     = 1'b0;
      err_evt    = 1'b0;
      err_code_d = 2'b00;
      if (byte_vld_in) begin
         case (state_q)
            S_IDLE: if (byte_in == HDR0) state_d = S_SYNC;
            S_SYNC: begin
               if (byte_in == HDR1)      state_d = S_ADDR;
               else if (byte_in != HDR0) state_d = S_IDLE;
            end
            S_ADDR: begin
               addr_d  = byte_in;
               sum_d   = byte_in;
               state_d = S_DHI;
            end
            S_DHI: begin
               hi_d    = byte_in;
               sum_d   = sum_q + byte_in;
               state_d = S_DLO;
            end
            S_DLO: begin
               lo_d    = byte_in;
               sum_d   = sum_q + byte_in;
               state_d = S_CSUM;
            end
            S_CSUM: begin
               state_d = S_IDLE;
               if (byte_in != sum_q) begin
                  err_evt    = 1'b1;
                  err_code_d = ERR_CSUM;
               end else if (addr_q > ADDR_MAX) begin
                  err_evt    = 1'b1;
                  err_code_d = ERR_ADDR;
               end else begin
                  wr_evt = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d    = S_IDLE;
            err_evt    = 1'b1;
            err_code_d = ERR_TIMEOUT;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_out        <= 1'b0;
         frame_err_out <= 1'b0;
         wr_addr_out   <= 8'h00;
         data_out      <= 16'h0000;
         err_code_out  <= 2'b00;
      end else begin
         wr_out        <= wr_evt;
         frame_err_out <= err_evt;
         if (wr_evt) begin
            wr_addr_out <= addr_q;
            data_out    <= {hi_q, lo_q};
         end
         if (err_evt) err_code_out <= err_code_d;
      end
   end

   assign busy_out = (state_q != S_IDLE);

   sat_cnt16 u_frame_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .clr   (1'b0),
      .inc   (wr_evt),
      .cnt   (frame_cnt_out)
   );

   sat_cnt16 u_err_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .clr   (1'b0),
      .inc   (err_evt),
      .cnt   (err_cnt_out)
   );

endmodule

// File: tb/tb_config_frame_parser.sv
// Directed-frame bench for config_frame_parser with an expected-response queue drained
// by an independent output monitor.
module tb_config_frame_parser;

   localparam int TMO = 5000;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_vld_in = 1'b0;
   logic        wr_out, frame_err_out, busy_out;
   logic [7:0]  wr_addr_out;
   logic [15:0] data_out, frame_cnt_out, err_cnt_out;
   logic [1:0]  err_code_out;

   int n_checks = 0;
   int n_errors = 0;

   // Entry: {is_err, code[1:0], addr[7:0], data[15:0], fcnt[15:0], ecnt[15:0]}
   logic [58:0] exp_q[$];
   logic [15:0] m_fcnt = 16'h0, m_ecnt = 16'h0, m_data = 16'h0;
   logic [7:0]  m_addr = 8'h0;
   logic [1:0]  m_code = 2'b00;

   always #5 clk_in = ~clk_in;

   config_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .byte_in       (byte_in),
      .byte_vld_in   (byte_vld_in),
      .wr_out        (wr_out),
      .wr_addr_out   (wr_addr_out),
      .data_out      (data_out),
      .frame_err_out (frame_err_out),
      .err_code_out  (err_code_out),
      .frame_cnt_out (frame_cnt_out),
      .err_cnt_out   (err_cnt_out),
      .busy_out      (busy_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Driver: called just after a rising edge, leaves us just after the next one.
   task automatic put_byte(input logic [7:0] b);
      byte_in     = b;
      byte_vld_in = 1'b1;
      @(posedge clk_in); #1;
      byte_vld_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in); #1;
      end
   endtask

   task automatic expect_write(input logic [7:0] a, input logic [15:0] d);
      if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'h1;
      m_addr = a;
      m_data = d;
      exp_q.push_back({1'b0, m_code, m_addr, m_data, m_fcnt, m_ecnt});
   endtask

   task automatic expect_err(input logic [1:0] code);
      if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'h1;
      m_code = code;
      exp_q.push_back({1'b1, m_code, m_addr, m_data, m_fcnt, m_ecnt});
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] cs);
      logic [7:0] s;
      s = a + hi + lo;
      put_byte(8'hEB);
      put_byte(8'h90);
      put_byte(a);
      put_byte(hi);
      put_byte(lo);
      if (cs != s)          expect_err(2'b10);
      else if (a > 8'd19)   expect_err(2'b11);
      else                  expect_write(a, {hi, lo});
      put_byte(cs);
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk_in);
      if (exp_q.size() != 0) begin
         check("drain_pending", exp_q.size(), 0);
         exp_q.delete();
      end
      @(posedge clk_in); #1;
   endtask

   // Monitor: every strobe must match the oldest expected response.
   always @(negedge clk_in) begin
      logic [58:0] e;
      if (rst_n_in && (wr_out || frame_err_out)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got wr=%0b err=%0b, expected none", wr_out, frame_err_out);
         end else begin
            e = exp_q.pop_front();
            check("strobe_wr",   wr_out,        !e[58]);
            check("strobe_err",  frame_err_out, e[58]);
            check("err_code",    err_code_out,  e[57:56]);
            check("wr_addr",     wr_addr_out,   e[55:48]);
            check("data",        data_out,      e[47:32]);
            check("frame_cnt",   frame_cnt_out, e[31:16]);
            check("err_cnt",     err_cnt_out,   e[15:0]);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"},        wr_out,        0);
      check({tag, "_err"},       frame_err_out, 0);
      check({tag, "_addr"},      wr_addr_out,   0);
      check({tag, "_data"},      data_out,      0);
      check({tag, "_code"},      err_code_out,  0);
      check({tag, "_frame_cnt"}, frame_cnt_out, 0);
      check({tag, "_err_cnt"},   err_cnt_out,   0);
      check({tag, "_busy"},      busy_out,      0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] hi, lo;
      repeat (3) @(posedge clk_in);
      #1;
      check_all_zero("reset");
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      // Good write, bad checksum, out-of-range address.
      send_frame(8'h03, 8'h00, 8'h55, 8'h58);
      send_frame(8'h02, 8'h00, 8'h01, 8'h04);
      send_frame(8'h14, 8'h00, 8'h00, 8'h14);
      drain(20);

      // Inter-byte timeout, then recovery with a clean frame.
      put_byte(8'hEB);
      put_byte(8'h90);
      put_byte(8'h05);
      expect_err(2'b01);
      idle(TMO - 1);
      check("busy_before_timeout", busy_out, 1);
      check("no_early_timeout", exp_q.size(), 1);
      idle(1);
      check("busy_after_timeout", busy_out, 0);
      drain(20);
      send_frame(8'h04, 8'h01, 8'h02, 8'h07);
      drain(20);

      // Leading garbage is silent; a doubled HDR0 resynchronises.
      put_byte(8'h7F);
      idle(3);
      check("garbage_busy", busy_out, 0);
      put_byte(8'hEB);
      send_frame(8'h01, 8'h12, 8'h34, 8'h47);
      drain(20);

      // Twenty back-to-back frames covering every legal address.
      for (int a = 0; a < 20; a++) begin
         hi = 8'(a) ^ 8'h5A;
         lo = ~8'(a);
         send_frame(8'(a), hi, lo, 8'(a) + hi + lo);
      end
      drain(50);

      // Reset in the middle of a frame discards it without side effects.
      put_byte(8'hEB);
      put_byte(8'h90);
      put_byte(8'h07);
      put_byte(8'h00);
      rst_n_in = 1'b0;
      #1;
      check_all_zero("midreset");
      m_fcnt = 16'h0; m_ecnt = 16'h0; m_addr = 8'h0; m_data = 16'h0; m_code = 2'b00;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      put_byte(8'h00);
      put_byte(8'h07);
      idle(5);
      check("post_reset_busy", busy_out, 0);
      send_frame(8'h0A, 8'h12, 8'h34, 8'h50);
      drain(20);

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
